imm_decode_stage: RTL

- Registered, handshaked immediate-decode stage for the RISC-V core; successor to the combinational immediate generator.
- Detects instruction format from the opcode itself, so no external select is needed.
- Produces an XLEN-wide immediate plus a format code, and buffers up to two instructions in a skid buffer so decode can stall without a combinational ready path.
- Sits between fetch and the register-read/execute stages.

---
 rtl/imm_decode_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/imm_decode_stage.sv
// Registered RISC-V immediate-decode stage with a 2-entry skid FIFO between fetch and execute.
// Optional define IMM_ZICSR_EN: CSR immediate forms (CSRRWI/CSRRSI/CSRRCI) decode as fmt Z.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [31:0]      out_instr,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_SH = 3'd2;
    localparam logic [2:0] FMT_S  = 3'd3;
    localparam logic [2:0] FMT_B  = 3'd4;
    localparam logic [2:0] FMT_U  = 3'd5;
    localparam logic [2:0] FMT_J  = 3'd6;
`ifdef IMM_ZICSR_EN
    localparam logic [2:0] FMT_Z  = 3'd7;
`endif

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } dec_t;

    // Every immediate is first assembled as a 32-bit signed value, then widened.
    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [4:0] opc;
        logic [2:0] f3;
        opc       = ins[6:2];
        f3        = ins[14:12];
        d.imm     = '0;
        d.fmt     = FMT_R;
        d.illegal = 1'b0;
        if (ins[1:0] != 2'b11) begin
            d.illegal = 1'b1;
        end else begin
            case (opc)
                OPC_OP: begin
                    d.fmt = FMT_R;
                end
                OPC_LOAD, OPC_JALR: begin
                    d.fmt = FMT_I;
                    d.imm = sext32({{20{ins[31]}}, ins[31:20]});
                end
                OPC_OP_IMM: begin
                    if (f3 == 3'b001 || f3 == 3'b101) begin
                        // funct7 sits above the shamt field and must not leak into imm
                        d.fmt = FMT_SH;
                        if (XLEN == 64) d.imm = sext32({26'b0, ins[25:20]});
                        else            d.imm = sext32({27'b0, ins[24:20]});
                    end else begin
                        d.fmt = FMT_I;
                        d.imm = sext32({{20{ins[31]}}, ins[31:20]});
                    end
                end
                OPC_SYSTEM: begin
                    d.fmt = FMT_I;
                    d.imm = sext32({{20{ins[31]}}, ins[31:20]});
`ifdef IMM_ZICSR_EN
                    if (f3[2] && (f3[1:0] != 2'b00)) begin
                        d.fmt = FMT_Z;
                        d.imm = sext32({27'b0, ins[19:15]});
                    end
`endif
                end
                OPC_STORE: begin
                    d.fmt = FMT_S;
                    d.imm = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
                end
                OPC_BRANCH: begin
                    d.fmt = FMT_B;
                    d.imm = sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                end
                OPC_LUI, OPC_AUIPC: begin
                    d.fmt = FMT_U;
                    d.imm = sext32({ins[31:12], 12'b0});
                end
                OPC_JAL: begin
                    d.fmt = FMT_J;
                    d.imm = sext32({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
                end
                default: begin
                    d.illegal = 1'b1;
                end
            endcase
        end
        return d;
    endfunction

    logic [1:0]       count_q, count_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    dec_t             ent_q [2];
    logic [31:0]      ins_q [2];
    logic [TAG_W-1:0] tag_q [2];

    dec_t             dec_in;
    logic             push;
    logic             pop;

    assign dec_in    = decode(in_instr);
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (flush) begin
            count_d = 2'd0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end else begin
            if (push) wr_d = ~wr_q;
            if (pop)  rd_d = ~rd_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Storage is cleared on reset so the outputs read zero while empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ent_q[i] <= '0;
                ins_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (push) begin
            ent_q[wr_q] <= dec_in;
            ins_q[wr_q] <= in_instr;
            tag_q[wr_q] <= in_tag;
        end
    end

    assign out_imm     = ent_q[rd_q].imm;
    assign out_fmt     = ent_q[rd_q].fmt;
    assign out_illegal = ent_q[rd_q].illegal;
    assign out_instr   = ins_q[rd_q];
    assign out_tag     = tag_q[rd_q];

endmodule
